cpu2core_sysid_checker: RTL and testbench

//  Avalon-MM master that reads a system-ID slave (word 0 = ID, word 1 = timestamp).
//  On a start pulse it compares both words against expected values and reports pass/fail.

---
 rtl/cpu2core_sysid_checker.sv | 172 +++++++++++++++++
 tb/tb_cpu2core_sysid_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu2core_sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (ID, then timestamp) on start and reports pass/fail.
// Optional retry-on-mismatch is enabled by defining SYSID_CHECK_RETRY_EN.
module cpu2core_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1446555800,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  error_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_ID, S_LAT_ID, S_REQ_TS, S_LAT_TS, S_CHECK, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK = 2'b00, ERR_ID = 2'b01, ERR_TS = 2'b10, ERR_TIMEOUT = 2'b11
  } err_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LAT_LAST  = 2'(READ_LATENCY);
  localparam bit          NO_LAT    = (READ_LATENCY == 0);

  if (READ_LATENCY < 0 || READ_LATENCY > 3 || TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES > 65535 || MAX_RETRIES < 0) begin : g_bad_params
    $error("cpu2core_sysid_checker: parameter out of range");
  end

  state_t      state;
  logic [15:0] wait_cnt;
  logic [1:0]  lat_cnt;
  err_t        check_code;
  logic        retry_ok;

  // NOTE: every variable gets a default first, so this block can never infer a latch.
  always_comb begin
    check_code = ERR_OK;
    if (id_value != EXPECTED_ID)      check_code = ERR_ID;
    else if (ts_value != EXPECTED_TS) check_code = ERR_TS;
  end

`ifdef SYSID_CHECK_RETRY_EN
  logic [15:0] retry_cnt;

  assign retry_ok = (check_code != ERR_OK) && (int'(retry_cnt) < MAX_RETRIES);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          retry_cnt <= '0;
    else if (state == S_IDLE && start)     retry_cnt <= '0;
    else if (state == S_CHECK && retry_ok) retry_cnt <= retry_cnt + 16'd1;
  end
`else
  assign retry_ok = 1'b0;
`endif

  // NOTE: state and registered outputs use <= so every branch reads the same pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      error_code  <= ERR_OK;
      id_value    <= '0;
      ts_value    <= '0;
      wait_cnt    <= '0;
      lat_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pass        <= 1'b0;
            error_code  <= ERR_OK;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            wait_cnt    <= '0;
            state       <= S_REQ_ID;
          end
        end

        S_REQ_ID, S_REQ_TS: begin
          if (!avm_waitrequest) begin
            wait_cnt <= '0;
            lat_cnt  <= 2'd1;
            if (NO_LAT) begin
              // Zero latency: data is valid in the accept cycle, so chain straight on.
              if (state == S_REQ_ID) begin
                id_value    <= avm_readdata;
                avm_address <= 1'b1;
                state       <= S_REQ_TS;
              end else begin
                ts_value <= avm_readdata;
                avm_read <= 1'b0;
                state    <= S_CHECK;
              end
            end else begin
              avm_read <= 1'b0;
              state    <= (state == S_REQ_ID) ? S_LAT_ID : S_LAT_TS;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            if (wait_cnt == WAIT_LAST) begin
              avm_read   <= 1'b0;
              error_code <= ERR_TIMEOUT;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= S_DONE;
            end
          end
        end

        S_LAT_ID: begin
          if (lat_cnt == LAT_LAST) begin
            id_value    <= avm_readdata;
            avm_read    <= 1'b1;
            avm_address <= 1'b1;
            state       <= S_REQ_TS;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        S_LAT_TS: begin
          if (lat_cnt == LAT_LAST) begin
            ts_value <= avm_readdata;
            state    <= S_CHECK;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        S_CHECK: begin
          error_code <= check_code;
          if (retry_ok) begin
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            state       <= S_REQ_ID;
          end else begin
            pass  <= (check_code == ERR_OK);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu2core_sysid_checker.sv
// Randomized self-checking bench for cpu2core_sysid_checker: behavioural Avalon slave plus
// a timing/result model derived from the read sequence rules.
module tb_cpu2core_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1446555800;
  localparam int RL   = 2;
  localparam int TMO  = 12;
  localparam int MAXR = 2;
`ifdef SYSID_CHECK_RETRY_EN
  localparam int RETRIES = MAXR;
`else
  localparam int RETRIES = 0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_address, avm_read, busy, done, pass;
  logic [1:0]  error_code;
  logic [31:0] id_value, ts_value;

  cpu2core_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(RL),
    .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(busy), .done(done), .pass(pass), .error_code(error_code),
    .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave memory, per-read stall plan and observed bus statistics.
  logic [31:0] mem_id, mem_ts, pend_word, slv_word;
  int          stall_id, stall_ts, stall_left, pend_left;
  bit          in_req, stalled_prev;
  logic        req_addr;
  int          read_cycles, accepts, aborts;

  // Values the DUT should hold in id_value/ts_value after the last run.
  logic [31:0] m_id, m_ts;

  initial begin
    mem_id = '0; mem_ts = '0; pend_word = '0; slv_word = '0;
    stall_id = 0; stall_ts = 0; stall_left = 0; pend_left = 0;
    in_req = 0; stalled_prev = 0; req_addr = 0;
    read_cycles = 0; accepts = 0; aborts = 0;
    forever begin
      @(negedge clock);
      avm_readdata = $urandom;
      if (pend_left > 0) begin
        pend_left--;
        if (pend_left == 0) avm_readdata = pend_word;
      end
      if (avm_read) begin
        read_cycles++;
        if (!in_req) begin
          in_req     = 1;
          req_addr   = avm_address;
          stall_left = avm_address ? stall_ts : stall_id;
        end else if (stalled_prev) begin
          check("addr_hold", 32'(avm_address), 32'(req_addr));
        end
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
          stalled_prev = 1;
        end else begin
          avm_waitrequest = 1'b0;
          accepts++;
          in_req       = 0;
          stalled_prev = 0;
          slv_word     = req_addr ? mem_ts : mem_id;
          if (RL == 0) avm_readdata = slv_word;
          else begin
            pend_left = RL;
            pend_word = slv_word;
          end
        end
      end else begin
        if (stalled_prev) aborts++;
        stalled_prev    = 0;
        in_req          = 0;
        avm_waitrequest = 1'($urandom);
      end
    end
  end

  // Cycle numbering: the cycle in which start is high is cycle 1.
  task automatic model(input logic [31:0] idw, input logic [31:0] tsw, input int sid,
                       input int sts, output int done_cyc, output int rcyc,
                       output int nacc, output int nab, output logic [1:0] err);
    int s, ts_start, chk;
    s = 2; rcyc = 0; nacc = 0; nab = 0; err = 2'b00; done_cyc = 0;
    for (int a = 0; a <= RETRIES; a++) begin
      if (sid >= TMO) begin
        rcyc += TMO; nab++; err = 2'b11; done_cyc = s + TMO;
        return;
      end
      rcyc += sid + 1; nacc++; m_id = idw;
      ts_start = s + sid + 1 + RL;
      if (sts >= TMO) begin
        rcyc += TMO; nab++; err = 2'b11; done_cyc = ts_start + TMO;
        return;
      end
      rcyc += sts + 1; nacc++; m_ts = tsw;
      chk = ts_start + sts + 1 + RL;
      err = (idw != EXP_ID) ? 2'b01 : (tsw != EXP_TS) ? 2'b10 : 2'b00;
      done_cyc = chk + 1;
      if (err == 2'b00) return;
      s = chk + 1;
    end
  endtask

  task automatic run(input string name, input logic [31:0] idw, input logic [31:0] tsw,
                     input int sid, input int sts, input bit poke);
    int exp_done, exp_rc, exp_acc, exp_ab, cyc, busy_cyc;
    logic [1:0] exp_err;
    bit seen;
    @(negedge clock);
    mem_id = idw; mem_ts = tsw; stall_id = sid; stall_ts = sts;
    read_cycles = 0; accepts = 0; aborts = 0;
    model(idw, tsw, sid, sts, exp_done, exp_rc, exp_acc, exp_ab, exp_err);
    start = 1'b1;
    cyc = 1; busy_cyc = 0; seen = 0;
    while (cyc < 3000) begin
      @(negedge clock);
      cyc++;
      start = (poke && cyc == 3);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_cyc++;
    end
    check({name, "/done_seen"}, 32'(seen), 32'd1);
    check({name, "/done_cycle"}, 32'(cyc), 32'(exp_done));
    check({name, "/busy_cycles"}, 32'(busy_cyc), 32'(exp_done - 2));
    check({name, "/busy_at_done"}, 32'(busy), 32'd0);
    check({name, "/pass"}, 32'(pass), 32'(exp_err == 2'b00));
    check({name, "/error_code"}, 32'(error_code), 32'(exp_err));
    check({name, "/id_value"}, id_value, m_id);
    check({name, "/ts_value"}, ts_value, m_ts);
    start = poke;
    @(negedge clock);
    start = 1'b0;
    check({name, "/done_pulse"}, 32'(done), 32'd0);
    check({name, "/idle_after"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    check({name, "/read_cycles"}, 32'(read_cycles), 32'(exp_rc));
    check({name, "/accepts"}, 32'(accepts), 32'(exp_acc));
    check({name, "/aborts"}, 32'(aborts), 32'(exp_ab));
  endtask

  initial begin
    logic [31:0] idw, tsw;
    int sid, sts;
    bit hit;
    m_id = '0; m_ts = '0;
    #1;
    check("rst/avm_read", 32'(avm_read), 32'd0);
    check("rst/avm_address", 32'(avm_address), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/pass", 32'(pass), 32'd0);
    check("rst/error_code", 32'(error_code), 32'd0);
    check("rst/id_value", id_value, 32'd0);
    check("rst/ts_value", ts_value, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    run("nominal",     EXP_ID,       EXP_TS,        0,       0,   0);
    run("id_bad",      32'h1,        EXP_TS,        0,       0,   0);
    run("ts_stall10",  EXP_ID,       EXP_TS,        0,       10,  1);
    run("id_stuck",    EXP_ID,       EXP_TS,        1000,    0,   0);
    run("id_edge",     EXP_ID,       EXP_TS,        TMO - 1, 0,   1);
    run("ts_timeout",  32'h5,        EXP_TS,        2,       TMO, 0);
    run("both_bad",    32'h7,        EXP_TS + 1,    1,       1,   0);
    run("ts_bad",      EXP_ID,       EXP_TS ^ 32'h8000_0000, 0, 3, 1);

    // Reset while the timestamp read is stalled.
    mem_id = EXP_ID; mem_ts = EXP_TS; stall_id = 0; stall_ts = 8;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (avm_read && avm_address) hit = 1;
      else @(negedge clock);
    end
    check("mid_rst/reached_req_ts", 32'(hit), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst/avm_read", 32'(avm_read), 32'd0);
    check("mid_rst/busy", 32'(busy), 32'd0);
    check("mid_rst/id_value", id_value, 32'd0);
    m_id = '0; m_ts = '0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    pend_left = 0;
    run("after_reset", EXP_ID, EXP_TS, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      idw = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      tsw = ($urandom_range(0, 3) == 0) ? (EXP_TS ^ (32'h1 << $urandom_range(0, 31))) : EXP_TS;
      sid = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 1, TMO + 3) : $urandom_range(0, 4);
      sts = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 1, TMO + 3) : $urandom_range(0, 4);
      run($sformatf("rand%0d", n), idw, tsw, sid, sts, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
